run_ctrl: RTL and testbench

Run sequencer and data-memory arbiter for the 9-bit accumulator core. It holds the core in reset while a host preloads data memory, releases the core, and counts executed cycles until `halt` or a watchdog timeout. It then returns the data-memory port to the host for result readback. It sits between TopLevel's core (IF/ALU/reg_file) and `data_mem`, owning the core's `start` input and the memory's single port.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/run_ctrl_if.sv | 62 ++++++
 rtl/run_cycle_ctr.sv | 40 ++++
 rtl/run_ctrl.sv | 127 ++++++++++++
 tb/tb_run_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and helpers for the run sequencer.
//   run_state_t : sequencer state (IDLE, RESET, RUN, DONE, TIMEOUT)
//   CNT_W       : width of the run/reset cycle counter
//   host_owns() : true in the states where the host owns the memory port
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_RESET   = 3'd1,
    RS_RUN     = 3'd2,
    RS_DONE    = 3'd3,
    RS_TIMEOUT = 3'd4
  } run_state_t;

  localparam int CNT_W = 16;

  function automatic logic host_owns(input run_state_t s);
    return (s == RS_IDLE) || (s == RS_DONE) || (s == RS_TIMEOUT);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: command, core, host, data-memory and status signals of the
// run sequencer.
//   slave  : the run_ctrl side (takes commands and requests, drives the
//            memory port, grants and status)
//   master : the environment side (host, core model, data_mem)
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
);
  // commands
  logic             cmd_go;
  logic             cmd_abort;
  // core side
  logic             core_start;
  logic             core_halt;
  logic             core_rd;
  logic             core_wr;
  logic [AW-1:0]    core_addr;
  logic [DW-1:0]    core_wdata;
  logic [DW-1:0]    core_rdata;
  // host side
  logic             host_req;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [DW-1:0]    host_wdata;
  logic             host_gnt;
  logic [DW-1:0]    host_rdata;
  // data memory port
  logic             mem_re;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  // status
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport slave (
    input  cmd_go, cmd_abort,
    input  core_halt, core_rd, core_wr, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output core_start, core_rdata, host_gnt, host_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    output busy, done, timeout, cycle_count
  );

  modport master (
    output cmd_go, cmd_abort,
    output core_halt, core_rd, core_wr, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  core_start, core_rdata, host_gnt, host_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  busy, done, timeout, cycle_count
  );

endinterface

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: up/down counter with synchronous clear, load and enable
// that stops when it reaches i_limit.
//   i_clk      : clock
//   i_clr      : synchronous clear to 0 (highest priority)
//   i_load     : load i_load_val
//   i_en       : count one step toward i_limit (up, or down when i_down)
//   i_limit    : terminal value; counting freezes there
//   o_count    : current value
//   o_at_limit : o_count == i_limit
module run_cycle_ctr
  import run_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_down,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_at_limit
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_en && !o_at_limit)
      r_count <= i_down ? r_count - W'(1) : r_count + W'(1);
  end

  assign o_count    = r_count;
  assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and data-memory arbiter for the accumulator core.
// Holds the core in reset while the host preloads memory, releases it after
// a go command, counts RUN cycles until halt or watchdog, then hands the
// memory back to the host.
//   CLK   : clock, posedge
//   start : synchronous active-high block reset
//   bus   : run_ctrl_if.slave (commands, core/host ports, memory port,
//           status and cycle_count)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
  parameter int          AW         = 8,
  parameter int          DW         = 8
) (
  input  logic     CLK,
  input  logic     start,
  run_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = RS_IDLE;
  localparam logic [2:0] ST_RESET   = RS_RESET;
  localparam logic [2:0] ST_RUN     = RS_RUN;
  localparam logic [2:0] ST_DONE    = RS_DONE;
  localparam logic [2:0] ST_TIMEOUT = RS_TIMEOUT;

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

  logic [2:0]       r_state, w_next;
  logic             w_in_reset, w_in_run, w_host_own, w_go_ok;
  logic             w_cnt_clr, w_cnt_en, w_at_lim, w_wdog;
  logic [CNT_W-1:0] w_cnt, w_lim;
  logic             w_mem_re, w_mem_we, w_host_gnt;
  logic [AW-1:0]    w_mem_addr;
  logic [DW-1:0]    w_mem_wdata;

  assign w_in_reset = (r_state == ST_RESET);
  assign w_in_run   = (r_state == ST_RUN);
  assign w_host_own = host_owns(run_state_t'(r_state));
  assign w_go_ok    = bus.cmd_go && w_host_own;
  // this RUN cycle will bring the count to the watchdog limit
  assign w_wdog     = w_at_lim || (w_cnt == MAX_CYCLES - 16'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_TIMEOUT:
        if (bus.cmd_go) w_next = ST_RESET;
      ST_RESET:
        if (w_at_lim) w_next = ST_RUN;
      ST_RUN: begin
        if (bus.cmd_abort)      w_next = ST_IDLE;
        else if (bus.core_halt) w_next = ST_DONE;
        else if (w_wdog)        w_next = ST_TIMEOUT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // One counter serves both phases: in RESET it counts down from
  // RST_CYCLES-1 to 0, then it is cleared on entry to RUN and counts RUN
  // cycles up to MAX_CYCLES. An aborted cycle is not counted.
  assign w_cnt_clr = start || (w_in_reset && w_at_lim);
  assign w_cnt_en  = w_in_reset ||
                     (w_in_run && !bus.core_halt && !bus.cmd_abort);
  assign w_lim     = w_in_reset ? '0 : MAX_CYCLES;

  run_cycle_ctr #(.W(CNT_W)) u_ctr (
    .i_clk      (CLK),
    .i_clr      (w_cnt_clr),
    .i_load     (w_go_ok),
    .i_load_val (RST_LOAD),
    .i_en       (w_cnt_en),
    .i_down     (w_in_reset),
    .i_limit    (w_lim),
    .o_count    (w_cnt),
    .o_at_limit (w_at_lim)
  );

  // Fixed owner by state. The RESET countdown value is hidden so the
  // visible count reads 0 from the go edge onward.
  always_comb begin
    w_mem_addr  = bus.host_addr;
    w_mem_wdata = bus.host_wdata;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    w_host_gnt  = 1'b0;
    if (w_in_run) begin
      w_mem_addr  = bus.core_addr;
      w_mem_wdata = bus.core_wdata;
      w_mem_re    = bus.core_rd;
      w_mem_we    = bus.core_wr;
    end else if (w_host_own) begin
      w_host_gnt = bus.host_req;
      w_mem_re   = bus.host_req && !bus.host_we;
      w_mem_we   = bus.host_req && bus.host_we;
    end
    // block reset this cycle: nothing may reach memory
    if (start) begin
      w_mem_re   = 1'b0;
      w_mem_we   = 1'b0;
      w_host_gnt = 1'b0;
    end
  end

  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.mem_re      = w_mem_re;
  assign bus.mem_we      = w_mem_we;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

  // DONE keeps core_start low so the halted core state stays readable
  assign bus.core_start  = !(w_in_run || (r_state == ST_DONE));
  assign bus.busy        = w_in_reset || w_in_run;
  assign bus.done        = (r_state == ST_DONE);
  assign bus.timeout     = (r_state == ST_TIMEOUT);
  assign bus.cycle_count = w_in_reset ? '0 : w_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int          AW   = 8;
  localparam int          DW   = 8;
  localparam int          RSTC = 2;
  localparam logic [15:0] MAXC = 16'd50;

  logic CLK = 1'b0;
  logic start;
  always #5 CLK = ~CLK;

  run_ctrl_if #(.AW(AW), .DW(DW)) bus();

  run_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .AW(AW), .DW(DW)) dut (
    .CLK   (CLK),
    .start (start),
    .bus   (bus)
  );

  // data_mem stand-in: combinational read, posedge write
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic [AW-1:0] wq [$];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge CLK) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic clr_in();
    bus.cmd_go = 0; bus.cmd_abort = 0; bus.core_halt = 0;
    bus.core_rd = 0; bus.core_wr = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = a;
    #1;
    chk({tag, "_gnt"}, bus.host_gnt, 1);
    chk({tag, "_rd"}, bus.host_rdata, exp);
    cyc();
    bus.host_req = 0;
  endtask

  // go pulse, then RSTC cycles of held core reset with the host blocked
  task automatic launch(input string tag);
    bus.cmd_go = 1;
    cyc();
    bus.cmd_go = 0;
    chk({tag, "_clr"}, bus.cycle_count, 0);
    for (int i = 0; i < RSTC; i++) begin
      bus.host_req = 1; bus.host_we = 1;
      bus.host_addr = 8'(i); bus.host_wdata = 8'hEE;
      bus.cmd_go = 1'($urandom_range(0, 1));   // ignored while busy
      #1;
      chk({tag, "_rst_cs"}, bus.core_start, 1);
      chk({tag, "_rst_busy"}, bus.busy, 1);
      chk({tag, "_rst_gnt"}, bus.host_gnt, 0);
      chk({tag, "_rst_we"}, bus.mem_we, 0);
      cyc();
    end
    clr_in();
    #1;
    chk({tag, "_release"}, bus.core_start, 0);
  endtask

  // h RUN cycles with random core traffic and blocked host, then halt
  task automatic run_body(input int h, input bit demo, input string tag);
    logic [7:0] a, d;
    for (int k = 0; k < h; k++) begin
      a = 8'($urandom_range(16, 255));
      d = 8'($urandom);
      bus.core_wr = 1'($urandom_range(0, 1));
      if (demo && k == 0) begin bus.core_wr = 1; a = 8'd7; d = 8'hA5; end
      bus.core_rd = !bus.core_wr;
      bus.core_addr = a; bus.core_wdata = d;
      bus.host_req = 1; bus.host_we = 1'($urandom_range(0, 1));
      bus.host_addr = 8'($urandom); bus.host_wdata = 8'($urandom);
      bus.cmd_go = ($urandom_range(0, 7) == 0);  // ignored in RUN
      #1;
      chk({tag, "_hgnt"}, bus.host_gnt, 0);
      chk({tag, "_maddr"}, bus.mem_addr, a);
      chk({tag, "_mwe"}, bus.mem_we, bus.core_wr);
      if (bus.core_wr) begin
        chk({tag, "_mwd"}, bus.mem_wdata, d);
        ref_mem[a] = d;
        wq.push_back(a);
      end else begin
        chk({tag, "_crd"}, bus.core_rdata, ref_mem[a]);
      end
      cyc();
    end
    clr_in();
    bus.core_halt = 1;
    #1;
    chk({tag, "_halt_cs"}, bus.core_start, 0);
    cyc();
    bus.core_halt = 0;
    #1;
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_count"}, bus.cycle_count, h);
    chk({tag, "_done_cs"}, bus.core_start, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    clr_in();
    start = 1;
    cyc(); cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tmo", bus.timeout, 0);
    chk("rst_cs", bus.core_start, 1);
    chk("rst_cnt", bus.cycle_count, 0);
    start = 0;

    // host preload in IDLE
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'd5; bus.host_wdata = 8'h3C;
    #1;
    chk("pre_wgnt", bus.host_gnt, 1);
    chk("pre_we", bus.mem_we, 1);
    chk("pre_cs", bus.core_start, 1);
    cyc();
    ref_mem[5] = 8'h3C;
    bus.host_we = 0;
    #1;
    chk("pre_re", bus.mem_re, 1);
    chk("pre_cs2", bus.core_start, 1);
    host_read(8'd5, 8'h3C, "pre_rd");

    // normal run of 20 cycles with the arbitration demo write
    launch("run1");
    run_body(20, 1'b1, "run1");
    // DONE: core enables masked, abort ignored
    bus.core_wr = 1; bus.core_addr = 8'd3; bus.core_wdata = 8'h99; bus.cmd_abort = 1;
    #1;
    chk("done_mask", bus.mem_we, 0);
    cyc();
    clr_in();
    #1;
    chk("done_abort_ign", bus.done, 1);
    host_read(8'd7, 8'hA5, "arb_rd");
    host_read(8'd3, 8'h00, "mask_rd");

    // reruns with random halt points
    for (int r = 0; r < 3; r++) begin
      launch("rerun");
      run_body($urandom_range(0, 45), 1'b0, "rerun");
    end
    foreach (wq[i]) host_read(wq[i], ref_mem[wq[i]], "readback");
    host_read(8'd0, ref_mem[0], "rstblk_rd0");
    host_read(8'd1, ref_mem[1], "rstblk_rd1");

    // watchdog
    launch("wdog");
    for (int k = 0; k < MAXC; k++) begin
      #1;
      chk("wdog_pre", bus.timeout, 0);
      cyc();
    end
    chk("wdog_tmo", bus.timeout, 1);
    chk("wdog_cnt", bus.cycle_count, MAXC);
    chk("wdog_cs", bus.core_start, 1);
    chk("wdog_busy", bus.busy, 0);
    host_read(8'd5, ref_mem[5], "wdog_rd");

    // abort in the same cycle as halt
    launch("abort");
    repeat (5) cyc();
    bus.cmd_abort = 1; bus.core_halt = 1;
    cyc();
    clr_in();
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_tmo", bus.timeout, 0);
    chk("abort_cs", bus.core_start, 1);
    bus.host_req = 1;
    #1;
    chk("abort_gnt", bus.host_gnt, 1);
    cyc();
    clr_in();

    // block reset mid-run, with a core write that must not land
    launch("srst");
    repeat (3) cyc();
    start = 1; bus.core_wr = 1; bus.core_addr = 8'd9; bus.core_wdata = 8'h77;
    #1;
    chk("srst_we", bus.mem_we, 0);
    cyc();
    start = 0;
    clr_in();
    #1;
    chk("srst_busy", bus.busy, 0);
    chk("srst_cnt", bus.cycle_count, 0);
    chk("srst_cs", bus.core_start, 1);
    host_read(8'd9, ref_mem[9], "srst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
